// File: rtl/multi_channel_accumulator.sv
// Multi-channel conv-layer output accumulator.
// Each beat sums NUM_IN signed partial products in a registered adder tree (S1).
// S2 accumulates the beat sums of one output group, then on the closing beat adds
// the bias, saturates, optionally applies ReLU and presents the result through a
// valid/ready output register. One global advance signal stalls every stage.
module multi_channel_accumulator #(
   parameter int DATA_W  = 32,
   parameter int NUM_IN  = 6,
   parameter int BIAS_W  = 8,
   parameter int OUT_W   = 32,
   parameter int GUARD_W = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NUM_IN*DATA_W-1:0]         in_data,
   input  logic                             in_first,
   input  logic                             in_last,
   input  logic signed [BIAS_W-1:0]         bias,
   input  logic                             relu_en,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic signed [OUT_W-1:0]          out_data,
   output logic                             out_sat,
   output logic                             grp_abort
);

   // Width of one beat sum and of the group accumulator.
   localparam int SW = DATA_W + $clog2(NUM_IN);
   localparam int IW = SW + GUARD_W;

   // Output range expressed at the accumulator-plus-one width used for the bias add.
   localparam logic signed [IW:0] OUT_MAX = {{(IW-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IW:0] OUT_MIN = ~OUT_MAX;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_OPEN = 1'b1
   } grp_state_e;

   // Clamp an IW+1 bit sum back into the IW bit accumulator range.
   function automatic logic signed [IW-1:0] sat_iw(input logic signed [IW:0] v);
      if (v[IW] != v[IW-1]) begin
         return v[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
      end
      return v[IW-1:0];
   endfunction

   // True when an IW+1 bit sum does not fit in IW bits.
   function automatic logic ovf_iw(input logic signed [IW:0] v);
      return v[IW] ^ v[IW-1];
   endfunction

   // Clamp the biased result into the OUT_W output range.
   function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [IW:0] v);
      if (v > OUT_MAX) begin
         return OUT_MAX[OUT_W-1:0];
      end
      if (v < OUT_MIN) begin
         return OUT_MIN[OUT_W-1:0];
      end
      return v[OUT_W-1:0];
   endfunction

   // True when the biased result had to be clamped.
   function automatic logic ovf_out(input logic signed [IW:0] v);
      return (v > OUT_MAX) || (v < OUT_MIN);
   endfunction

   // Optional rectifier: negative results become zero when enabled.
   function automatic logic signed [OUT_W-1:0] relu(input logic signed [OUT_W-1:0] v,
                                                    input logic en);
      if (en && v[OUT_W-1]) begin
         return '0;
      end
      return v;
   endfunction

   logic                     adv;

   logic signed [SW-1:0]     sum_d;
   logic                     vld_p1_q;
   logic signed [SW-1:0]     sum_p1_q;
   logic                     first_p1_q;
   logic                     last_p1_q;
   logic signed [BIAS_W-1:0] bias_p1_q;
   logic                     relu_p1_q;

   grp_state_e               state_q;
   logic signed [IW-1:0]     acc_q;
   logic                     grp_sat_q;
   logic                     out_valid_q;
   logic signed [OUT_W-1:0]  out_data_q;
   logic                     out_sat_q;
   logic                     grp_abort_q;

   logic                     grp_open;
   logic                     restart;
   logic signed [IW-1:0]     base;
   logic signed [IW:0]       nxt_wide;
   logic signed [IW-1:0]     nxt_d;
   logic                     sat_acc_d;
   logic signed [IW:0]       res_wide;
   logic signed [OUT_W-1:0]  res_d;
   logic                     res_sat_d;
   logic                     abort_d;

   // Everything moves unless a held result is still waiting for the consumer.
   assign adv      = !(out_valid_q && !out_ready);
   assign in_ready = adv;

   // ---- S0 -> S1: adder tree over the sign-extended input lanes ----
   // Sum all lanes of the incoming beat at full beat-sum width.
   always_comb begin
      sum_d = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         sum_d = sum_d + {{(SW-DATA_W){in_data[k*DATA_W+DATA_W-1]}},
                          in_data[k*DATA_W +: DATA_W]};
      end
   end

   // Register the beat sum together with its control flags and side-band.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q   <= 1'b0;
         sum_p1_q   <= '0;
         first_p1_q <= 1'b0;
         last_p1_q  <= 1'b0;
         bias_p1_q  <= '0;
         relu_p1_q  <= 1'b0;
      end else if (adv) begin
         vld_p1_q   <= in_valid;
         sum_p1_q   <= sum_d;
         first_p1_q <= in_first;
         last_p1_q  <= in_last;
         bias_p1_q  <= bias;
         relu_p1_q  <= relu_en;
      end
   end

   // ---- S1 -> S2: accumulate, and finish the group on its last beat ----
   // A beat restarts the sum when it is flagged first or when no group is open;
   // the saturation history restarts with it.
   always_comb begin
      grp_open  = (state_q == S_OPEN);
      restart   = first_p1_q || !grp_open;
      base      = restart ? '0 : acc_q;
      nxt_wide  = {base[IW-1], base} + {{(IW+1-SW){sum_p1_q[SW-1]}}, sum_p1_q};
      nxt_d     = sat_iw(nxt_wide);
      sat_acc_d = (!restart && grp_sat_q) || ovf_iw(nxt_wide);
      res_wide  = {nxt_d[IW-1], nxt_d} + {{(IW+1-BIAS_W){bias_p1_q[BIAS_W-1]}}, bias_p1_q};
      res_d     = relu(sat_out(res_wide), relu_p1_q);
      res_sat_d = sat_acc_d || ovf_out(res_wide);
      abort_d   = vld_p1_q && first_p1_q && grp_open;
   end

   // Group FSM, accumulator and the registered result/abort outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         grp_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         grp_abort_q <= 1'b0;
      end else begin
         // A stalled restart beat fires its abort pulse once, when it is consumed.
         grp_abort_q <= adv && abort_d;
         if (adv) begin
            // Either nothing was held or the held result is taken this cycle.
            out_valid_q <= vld_p1_q && last_p1_q;
            if (vld_p1_q) begin
               if (last_p1_q) begin
                  out_data_q <= res_d;
                  out_sat_q  <= res_sat_d;
                  acc_q      <= '0;
                  grp_sat_q  <= 1'b0;
                  state_q    <= S_IDLE;
               end else begin
                  acc_q      <= nxt_d;
                  grp_sat_q  <= sat_acc_d;
                  state_q    <= S_OPEN;
               end
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign grp_abort = grp_abort_q;

endmodule

// File: tb/tb_multi_channel_accumulator.sv
// Bench for multi_channel_accumulator: directed cases plus a randomized stream,
// all results scored against a beat-level arithmetic model of the group rules.
module tb_multi_channel_accumulator;

   localparam int DATA_W  = 32;
   localparam int NUM_IN  = 6;
   localparam int BIAS_W  = 8;
   localparam int OUT_W   = 32;
   localparam int GUARD_W = 4;
   localparam int IW      = DATA_W + $clog2(NUM_IN) + GUARD_W;

   localparam longint IW_MAX  = (longint'(1) <<< (IW-1)) - 1;
   localparam longint IW_MIN  = -(longint'(1) <<< (IW-1));
   localparam longint OUT_MAX = (longint'(1) <<< (OUT_W-1)) - 1;
   localparam longint OUT_MIN = -(longint'(1) <<< (OUT_W-1));

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      in_valid;
   logic                      in_ready;
   logic [NUM_IN*DATA_W-1:0]  in_data;
   logic                      in_first;
   logic                      in_last;
   logic signed [BIAS_W-1:0]  bias;
   logic                      relu_en;
   logic                      out_valid;
   logic                      out_ready;
   logic signed [OUT_W-1:0]   out_data;
   logic                      out_sat;
   logic                      grp_abort;

   multi_channel_accumulator #(
      .DATA_W(DATA_W), .NUM_IN(NUM_IN), .BIAS_W(BIAS_W), .OUT_W(OUT_W), .GUARD_W(GUARD_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_first(in_first), .in_last(in_last), .bias(bias), .relu_en(relu_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sat(out_sat), .grp_abort(grp_abort)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int lane_v [NUM_IN];

   // Reference model state (one entry per accepted beat, no pipeline notion).
   bit     m_open = 0;
   longint m_acc  = 0;
   bit     m_sat  = 0;
   int     m_aborts = 0;
   longint exp_d [$];
   bit     exp_s [$];

   int                    abort_seen = 0;
   bit                    stall_prev = 0;
   logic signed [OUT_W-1:0] prev_data;
   logic                  prev_sat;

   // Random beat generator state.
   int gen_rem = 0;
   bit pend = 0;
   bit pf, pl, pr;
   int pb;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_beat(input bit f, input bit l, input int b, input bit r);
      longint s, base, n, res;
      bit gs;
      s = 0;
      for (int k = 0; k < NUM_IN; k++) s += longint'(lane_v[k]);
      if (f && m_open) m_aborts++;
      if (f || !m_open) begin base = 0; gs = 0; end
      else begin base = m_acc; gs = m_sat; end
      n = base + s;
      if (n > IW_MAX) begin n = IW_MAX; gs = 1; end
      else if (n < IW_MIN) begin n = IW_MIN; gs = 1; end
      if (l) begin
         res = n + longint'(b);
         if (res > OUT_MAX) begin res = OUT_MAX; gs = 1; end
         else if (res < OUT_MIN) begin res = OUT_MIN; gs = 1; end
         if (r && res < 0) res = 0;
         exp_d.push_back(res);
         exp_s.push_back(gs);
         m_open = 0; m_acc = 0; m_sat = 0;
      end else begin
         m_open = 1; m_acc = n; m_sat = gs;
      end
   endtask

   // One clock: drive at the falling edge, sample 1 ns later, score handshakes.
   task automatic step(input bit v, input bit f, input bit l, input int b, input bit r,
                       input bit ordy, output bit acc);
      @(negedge clk);
      in_valid  = v;
      in_first  = f;
      in_last   = l;
      bias      = b[BIAS_W-1:0];
      relu_en   = r;
      out_ready = ordy;
      for (int k = 0; k < NUM_IN; k++) in_data[k*DATA_W +: DATA_W] = lane_v[k];
      #1;
      if (stall_prev) begin
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, prev_data);
         check("hold_sat", out_sat, prev_sat);
      end
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (grp_abort === 1'b1) abort_seen++;
      if (out_valid && out_ready) begin
         if (exp_d.size() == 0) check("unexpected_out", 1, 0);
         else begin
            check("out_data", out_data, exp_d.pop_front());
            check("out_sat", out_sat, exp_s.pop_front());
         end
      end
      acc = in_valid && in_ready;
      if (acc) model_beat(f, l, b, r);
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sat   = out_sat;
   endtask

   task automatic idle(input int n);
      bit a;
      repeat (n) step(0, 0, 0, 0, 0, 1, a);
   endtask

   task automatic set_lanes(input int val);
      for (int k = 0; k < NUM_IN; k++) lane_v[k] = val;
   endtask

   task automatic send(input bit f, input bit l, input int b, input bit r);
      bit a;
      step(1, f, l, b, r, 1, a);
      check("send_accepted", a, 1);
   endtask

   task automatic gen_beat(input bit force_single);
      int mode;
      if (gen_rem == 0 || force_single || $urandom_range(11) == 0) begin
         pf = (gen_rem != 0) ? 1'b1 : ($urandom_range(4) != 0);
         gen_rem = force_single ? 1 : int'($urandom_range(4, 1));
      end else begin
         pf = 0;
      end
      pl = (gen_rem == 1);
      gen_rem--;
      pb = int'($urandom_range(255)) - 128;
      pr = ($urandom_range(2) == 0);
      mode = int'($urandom_range(3));
      for (int k = 0; k < NUM_IN; k++) begin
         case (mode)
            1:       lane_v[k] = int'($urandom_range(2000)) - 1000;
            2:       lane_v[k] = ($urandom_range(1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: lane_v[k] = int'($urandom);
         endcase
      end
   endtask

   task automatic run_stream(input int ncyc, input int stall_at);
      bit a, win, ordy, v;
      for (int c = 0; c < ncyc; c++) begin
         win  = (c >= stall_at - 4) && (c < stall_at + 5);
         ordy = (c >= stall_at && c < stall_at + 5) ? 1'b0 :
                (win ? 1'b1 : ($urandom_range(3) != 0));
         v    = win ? 1'b1 : ($urandom_range(3) != 0);
         if (!pend) begin
            gen_beat(win);
            pend = 1;
         end
         step(v, pf, pl, pb, pr, ordy, a);
         if (a) pend = 0;
         if (c == stall_at + 4) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
         end
      end
   endtask

   initial begin
      int base_abort;
      rst_n = 0; in_valid = 0; in_first = 0; in_last = 0; bias = '0; relu_en = 0;
      out_ready = 0; in_data = '0;
      set_lanes(0);
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_grp_abort", grp_abort, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1;

      // Single beat, lanes 1..6, bias -5.
      for (int k = 0; k < NUM_IN; k++) lane_v[k] = k + 1;
      send(1, 1, -5, 0);
      idle(1);
      check("t1_lat_n1", out_valid, 0);
      idle(1);
      check("t1_lat_n2", out_valid, 1);
      check("t1_data", out_data, 16);
      check("t1_sat", out_sat, 0);

      // Three beats of 100 per lane, bias 7.
      set_lanes(100);
      send(1, 0, 0, 0);
      check("t2_b1_noout", out_valid, 0);
      send(0, 0, 0, 0);
      check("t2_b2_noout", out_valid, 0);
      send(0, 1, 7, 0);
      check("t2_b3_noout", out_valid, 0);
      idle(1);
      check("t2_noout", out_valid, 0);
      idle(1);
      check("t2_data", out_data, 1807);

      // Output saturation high, then negative saturation clamped by ReLU.
      set_lanes(32'h7FFF_FFFF);
      send(1, 1, 0, 0);
      idle(2);
      check("t3_max_data", out_data, 32'sh7FFF_FFFF);
      check("t3_max_sat", out_sat, 1);
      set_lanes(32'h8000_0000);
      send(1, 1, 0, 1);
      idle(2);
      check("t3_relu_data", out_data, 0);
      check("t3_relu_sat", out_sat, 1);
      set_lanes(-1);
      send(1, 1, -1, 1);
      idle(2);
      check("t3_relu_small", out_data, 0);
      check("t3_relu_small_sat", out_sat, 0);
      send(1, 1, -1, 0);
      idle(2);
      check("t3_neg_data", out_data, -7);

      // Accumulator saturation sticks: climb past the top, then come back down.
      set_lanes(32'h7FFF_FFFF);
      for (int i = 0; i < 25; i++) send(i == 0, 0, 0, 0);
      set_lanes(32'h8000_0000);
      for (int i = 0; i < 21; i++) send(0, 0, 0, 0);
      set_lanes(-715827882);
      send(0, 1, 0, 0);
      idle(2);
      check("t4_iwsat_data", out_data, 3);
      check("t4_iwsat_sat", out_sat, 1);

      // Restart in the middle of a group.
      base_abort = abort_seen;
      set_lanes(1000);
      send(1, 0, 0, 0);
      send(0, 0, 0, 0);
      set_lanes(5);
      send(1, 1, 0, 0);
      idle(2);
      check("t5_data", out_data, 30);
      idle(2);
      check("t5_abort_once", abort_seen - base_abort, 1);

      // Reset in the middle of an open group.
      set_lanes(50);
      send(1, 0, 0, 0);
      idle(1);
      @(negedge clk);
      rst_n = 0;
      #1;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_data", out_data, 0);
      check("t6_rst_sat", out_sat, 0);
      check("t6_rst_abort", grp_abort, 0);
      @(negedge clk);
      rst_n = 1;
      m_open = 0; m_acc = 0; m_sat = 0;
      exp_d.delete(); exp_s.delete();
      stall_prev = 0;
      set_lanes(2);
      send(0, 1, 1, 0);
      idle(2);
      check("t6_fresh_data", out_data, 13);
      check("t6_fresh_sat", out_sat, 0);

      // Randomized stream with random back-pressure and one forced 5-cycle stall.
      run_stream(600, 300);
      idle(8);
      check("drain_empty", exp_d.size(), 0);
      check("abort_total", abort_seen, m_aborts);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
